gshare_ghr: RTL and testbench

Global-history front end for the branch predictor: holds a speculative global history register (GHR), forms the gshare index into the 1024-entry pattern history table for the fetch stage, and carries per-instruction prediction metadata through D and E. In E it returns the index the PHT trains on, flags mispredictions, and repairs the GHR on any E-stage redirect. It sits between the fetch/PC logic (upstream) and the PHT (downstream). Fetch and the hazard unit consume its prediction and mispredict outputs.

---
 rtl/bp_pkg.sv | 25 ++
 rtl/gshare_ghr_if.sv | 35 +++
 rtl/bp_meta_pipe.sv | 25 ++
 rtl/gshare_ghr.sv | 85 ++++++++
 tb/tb_gshare_ghr.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types for the gshare global-history front end.
//   HIST_BITS  : GHR width, equal to the PHT index width
//   IDX_LO     : lowest PC bit folded into the PHT index
//   bp_idx_t   : one PHT index / one GHR value
//   bp_meta_t  : per-instruction prediction metadata carried F -> D -> E
package bp_pkg;

    localparam int HIST_BITS = 10;
    localparam int IDX_LO    = 2;

    typedef logic [HIST_BITS-1:0] bp_idx_t;

    typedef struct packed {
        logic    valid;
        bp_idx_t idx;
        bp_idx_t ghr_before;
        logic    pred;
    } bp_meta_t;

    // Shift one outcome into a history value; the oldest bit falls off the top.
    function automatic bp_idx_t ghr_shift(input bp_idx_t hist, input logic outcome);
        return {hist[HIST_BITS-2:0], outcome};
    endfunction

endpackage

// File: rtl/gshare_ghr_if.sv
// Bundle of the fetch/hazard-side signals of the gshare front end.
//   master : fetch, hazard unit and E-stage resolve logic (drive the controls)
//   slave  : gshare_ghr (drives the index, prediction and mispredict outputs)
interface gshare_ghr_if;
    import bp_pkg::*;

    logic [31:0] PCF;
    logic        br_predecodeF;
    logic        pht_taken;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic        BranchE;
    logic        br_actualE;
    logic        RedirectE;
    bp_idx_t     pht_indexF;
    logic        predict_takenF;
    bp_idx_t     pht_indexE;
    logic        mispredictE;
    bp_idx_t     ghr_out;

    modport master (
        output PCF, br_predecodeF, pht_taken, StallF, StallD, FlushD, FlushE,
               BranchE, br_actualE, RedirectE,
        input  pht_indexF, predict_takenF, pht_indexE, mispredictE, ghr_out
    );

    modport slave (
        input  PCF, br_predecodeF, pht_taken, StallF, StallD, FlushD, FlushE,
               BranchE, br_actualE, RedirectE,
        output pht_indexF, predict_takenF, pht_indexE, mispredictE, ghr_out
    );

endinterface

// File: rtl/bp_meta_pipe.sv
// One stage register for prediction metadata.
//   clk, reset : clock and synchronous active-high reset (clears the stage)
//   stall      : hold the current contents
//   flush      : load a bubble (all zeros); wins over stall
//   d, q       : metadata in / out
module bp_meta_pipe
    import bp_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     stall,
    input  logic     flush,
    input  bp_meta_t d,
    output bp_meta_t q
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/gshare_ghr.sv
// Speculative global history register and gshare index generation.
// Forms the PHT index for fetch, carries prediction metadata through D and E,
// flags E-stage mispredictions and restores the GHR on any E-stage redirect.
//   clk, reset : clock, synchronous active-high reset
//   bp         : gshare_ghr_if.slave (PCF, predecode, PHT result, stalls,
//                flushes, E-stage resolve in; indices, prediction,
//                mispredict and GHR out)
module gshare_ghr
    import bp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    gshare_ghr_if.slave bp
);

    bp_idx_t  ghr;
    bp_idx_t  idx_f_p0;
    logic     pred_f_p0;
    bp_meta_t meta_f_p0;
    bp_meta_t meta_d_p1;
    bp_meta_t meta_de_p1;
    bp_meta_t meta_e_p2;
    logic     pred_e_p2;

    // PC bits outside the index window do not take part in prediction.
    logic unused_pc;
    assign unused_pc = ^{bp.PCF[31:IDX_LO+HIST_BITS], bp.PCF[IDX_LO-1:0]};

    // ---- F stage: index and prediction, zero latency from PCF ----
    assign idx_f_p0  = bp.PCF[IDX_LO+HIST_BITS-1:IDX_LO] ^ ghr;
    assign pred_f_p0 = bp.br_predecodeF & bp.pht_taken;

    assign meta_f_p0 = '{valid: 1'b1, idx: idx_f_p0, ghr_before: ghr, pred: pred_f_p0};

    // A redirect restores history from the E instruction's fetch-time snapshot
    // and takes precedence over the wrong-path fetch shift in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr <= '0;
        end else if (bp.RedirectE) begin
            ghr <= bp.BranchE ? ghr_shift(meta_e_p2.ghr_before, bp.br_actualE)
                              : meta_e_p2.ghr_before;
        end else if (!bp.StallF && bp.br_predecodeF) begin
            ghr <= ghr_shift(ghr, bp.pht_taken);
        end
    end

    // ---- F -> D boundary ----
    bp_meta_pipe u_pipe_d (
        .clk   (clk),
        .reset (reset),
        .stall (bp.StallD),
        .flush (bp.FlushD),
        .d     (meta_f_p0),
        .q     (meta_d_p1)
    );

    // While D holds, its instruction must not also advance into E, so the copy
    // that E sees is marked invalid.
    always_comb begin
        meta_de_p1       = meta_d_p1;
        meta_de_p1.valid = meta_d_p1.valid & ~bp.StallD;
    end

    // ---- D -> E boundary ----
    bp_meta_pipe u_pipe_e (
        .clk   (clk),
        .reset (reset),
        .stall (1'b0),
        .flush (bp.FlushE),
        .d     (meta_de_p1),
        .q     (meta_e_p2)
    );

    // ---- E stage: training index and mispredict ----
    // An invalid E slot is treated as predicted not-taken.
    assign pred_e_p2      = meta_e_p2.valid & meta_e_p2.pred;
    assign bp.pht_indexE  = meta_e_p2.idx;
    assign bp.mispredictE = bp.BranchE & (pred_e_p2 != bp.br_actualE);

    assign bp.pht_indexF     = idx_f_p0;
    assign bp.predict_takenF = pred_f_p0;
    assign bp.ghr_out        = ghr;

endmodule

// File: tb/tb_gshare_ghr.sv
module tb_gshare_ghr;
    import bp_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gshare_ghr_if bp_if ();

    gshare_ghr dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp_if.slave)
    );

    typedef struct {
        int idx_f;
        bit pt_f;
        int idx_e;
        bit mis_e;
        int ghr;
    } exp_t;

    typedef struct {
        bit valid;
        int idx;
        int ghr_before;
        bit pred;
    } slot_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: history as an integer, one record per occupied stage.
    int    m_ghr;
    slot_t m_d, m_e;
    slot_t empty_slot = '{valid: 0, idx: 0, ghr_before: 0, pred: 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic int pc_index(input logic [31:0] pc);
        return int'((pc >> IDX_LO) % (1 << HIST_BITS));
    endfunction

    function automatic int push_hist(input int h, input bit b);
        return (h * 2 + int'(b)) % (1 << HIST_BITS);
    endfunction

    // Drive one cycle's inputs at the falling edge and queue the outputs the
    // model expects for that cycle.
    task automatic drive(input logic [31:0] pc, input bit br, input bit pt,
                         input bit sf = 0, input bit sd = 0, input bit fd = 0,
                         input bit fe = 0, input bit be = 0, input bit ba = 0,
                         input bit re = 0, input bit rst = 0);
        exp_t e;
        @(negedge clk);
        reset               = rst;
        bp_if.PCF           = pc;
        bp_if.br_predecodeF = br;
        bp_if.pht_taken     = pt;
        bp_if.StallF        = sf;
        bp_if.StallD        = sd;
        bp_if.FlushD        = fd;
        bp_if.FlushE        = fe;
        bp_if.BranchE       = be;
        bp_if.br_actualE    = ba;
        bp_if.RedirectE     = re;
        #1;
        e.idx_f = pc_index(pc) ^ m_ghr;
        e.pt_f  = br && pt;
        e.idx_e = m_e.idx;
        e.mis_e = be && ((m_e.valid && m_e.pred) != ba);
        e.ghr   = m_ghr;
        sb.push_back(e);
    endtask

    // Advance the model across the rising edge using the inputs in force.
    task automatic tick();
        slot_t nd, ne;
        int    ng;
        @(posedge clk);
        if (reset) begin
            m_ghr = 0;
            m_d   = empty_slot;
            m_e   = empty_slot;
        end else begin
            if (bp_if.FlushE) ne = empty_slot;
            else begin
                ne = m_d;
                if (bp_if.StallD) ne.valid = 0;
            end
            if (bp_if.FlushD)      nd = empty_slot;
            else if (bp_if.StallD) nd = m_d;
            else nd = '{valid: 1, idx: pc_index(bp_if.PCF) ^ m_ghr, ghr_before: m_ghr,
                        pred: bp_if.br_predecodeF && bp_if.pht_taken};
            if (bp_if.RedirectE)
                ng = bp_if.BranchE ? push_hist(m_e.ghr_before, bp_if.br_actualE) : m_e.ghr_before;
            else if (!bp_if.StallF && bp_if.br_predecodeF)
                ng = push_hist(m_ghr, bp_if.pht_taken);
            else
                ng = m_ghr;
            m_ghr = ng;
            m_d   = nd;
            m_e   = ne;
        end
    endtask

    task automatic step(input logic [31:0] pc, input bit br, input bit pt,
                        input bit sf = 0, input bit sd = 0, input bit fd = 0,
                        input bit fe = 0, input bit be = 0, input bit ba = 0,
                        input bit re = 0, input bit rst = 0);
        drive(pc, br, pt, sf, sd, fd, fe, be, ba, re, rst);
        tick();
        #1;
    endtask

    // Monitor: every cycle, compare the DUT against the oldest queued expectation.
    initial begin
        forever begin : mon
            exp_t e;
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pht_indexF",     bp_if.pht_indexF,     e.idx_f);
                check("predict_takenF", bp_if.predict_takenF, e.pt_f);
                check("pht_indexE",     bp_if.pht_indexE,     e.idx_e);
                check("mispredictE",    bp_if.mispredictE,    e.mis_e);
                check("ghr_out",        bp_if.ghr_out,        e.ghr);
            end
        end
    end

    initial begin
        m_ghr = 0;
        m_d   = empty_slot;
        m_e   = empty_slot;
        reset = 1'b1;
        bp_if.PCF = 32'h0; bp_if.br_predecodeF = 0; bp_if.pht_taken = 0;
        bp_if.StallF = 0; bp_if.StallD = 0; bp_if.FlushD = 0; bp_if.FlushE = 0;
        bp_if.BranchE = 0; bp_if.br_actualE = 0; bp_if.RedirectE = 0;

        // Reset state
        step(32'h0, 0, 0, .rst(1));
        step(32'h0, 0, 0, .rst(1));
        drive(32'h0000_1008, 0, 0);
        check("reset_pht_indexF", bp_if.pht_indexF, 32'h002);
        check("reset_ghr_out",    bp_if.ghr_out,    32'h000);
        check("reset_pht_indexE", bp_if.pht_indexE, 32'h000);
        check("reset_mispredictE", bp_if.mispredictE, 32'h0);
        tick(); #1;

        // Back-to-back branches: taken, not-taken, taken
        step(32'h0000_1010, 1, 1);
        check("b2b_ghr_1", bp_if.ghr_out, 32'h001);
        step(32'h0000_1014, 1, 0);
        check("b2b_ghr_2", bp_if.ghr_out, 32'h002);
        check("b2b_first_idx_in_E", bp_if.pht_indexE, 32'h004);
        step(32'h0000_1018, 1, 1);
        check("b2b_ghr_3", bp_if.ghr_out, 32'h005);

        // Predicted-taken branch with ghr_before=0x005 resolves not-taken
        step(32'h0000_1020, 1, 1);
        step(32'h0000_1024, 0, 0);
        drive(32'h0000_1028, 1, 1, .fd(1), .fe(1), .be(1), .ba(0), .re(1));
        check("mispredict_flag", bp_if.mispredictE, 32'h1);
        tick(); #1;
        check("mispredict_repair", bp_if.ghr_out, 32'h00A);

        // F and D held for three cycles with a branch in F
        step(32'h0000_1040, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(32'h0000_1044, 1, 1, .sf(1), .sd(1));
            check("stall_ghr_held", bp_if.ghr_out, 32'h00A);
            check("stall_d_held",   bp_if.pht_indexE, 32'h01A);
        end
        step(32'h0000_1044, 1, 1);
        check("stall_release_shift", bp_if.ghr_out, 32'h015);

        // Load-use bubble: E flushed while D holds
        step(32'h0000_1048, 0, 0, .sf(1), .sd(1), .fe(1));
        check("bubble_E_idx", bp_if.pht_indexE, 32'h000);
        step(32'h0000_1048, 0, 0);
        check("bubble_then_D_idx", bp_if.pht_indexE, 32'h01B);

        // Jump in E restores history after wrong-path branch shifts
        step(32'h0, 0, 0, .rst(1));
        for (int i = 0; i < 10; i++) step(32'h0000_2000 + 4 * i, 1, (i % 2) == 0);
        check("wrap_ghr", bp_if.ghr_out, 32'h2AA);
        step(32'h0000_3000, 0, 0);
        step(32'h0000_3004, 1, 1);
        check("wrong_path_shift", bp_if.ghr_out, 32'h155);
        step(32'h0000_3008, 1, 1, .fd(1), .fe(1), .be(0), .re(1));
        check("jump_repair", bp_if.ghr_out, 32'h2AA);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            bit rst, br, pt, sf, sd, fd, fe, be, ba, re;
            rst = ($urandom_range(0, 99) < 2);
            br  = $urandom_range(0, 1);
            pt  = $urandom_range(0, 1);
            sf  = ($urandom_range(0, 6) == 0);
            sd  = sf ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
            fd  = ($urandom_range(0, 9) == 0);
            fe  = ($urandom_range(0, 9) == 0);
            be  = m_e.valid ? $urandom_range(0, 1) : ($urandom_range(0, 19) == 0);
            ba  = $urandom_range(0, 1);
            re  = ($urandom_range(0, 4) == 0);
            step($urandom, br, pt, sf, sd, fd, fe, be, ba, re, rst);
        end

        repeat (3) @(negedge clk);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
